// File: rtl/wts_channel_mixer_pkg.sv
// Shared types and constants for the wave-table channel mixer.
// The envelope full-scale value is also used by the ADSR generators.
package wts_channel_mixer_pkg;

   localparam int unsigned SAMPLE_W = 8;
   localparam int unsigned VOL_W    = 4;
   localparam int unsigned ENV_W    = 9;
   localparam int unsigned T1_W     = 9;
   localparam int unsigned CH_W     = 4;

   localparam logic [ENV_W-1:0] ENV_FULL = ENV_W'(256);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Stage-1 payload handed from the scaler to the accumulate stage.
   typedef struct packed {
      logic signed [T1_W-1:0] t1;
      logic [VOL_W-1:0]       vol;
   } stage1_t;

   function automatic logic [ENV_W-1:0] env_clamp(input logic [ENV_W-1:0] env);
      return (env > ENV_FULL) ? ENV_FULL : env;
   endfunction

endpackage

// File: rtl/wts_channel_scaler.sv
// Stage 1: registers t1 = (sample * min(env,256)) >>> 8, gated by the channel enable.
// The channel volume is captured alongside so stage 2 sees the matching channel.
module wts_channel_scaler
   import wts_channel_mixer_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       active_i,
   input  logic                       load_i,
   input  logic                       ch_on_i,
   input  logic signed [SAMPLE_W-1:0] wave_sample_i,
   input  logic [ENV_W-1:0]           envelope_i,
   input  logic [VOL_W-1:0]           volume_i,
   output stage1_t                    s1_o
);

   logic signed [ENV_W:0]          env_s;
   logic signed [SAMPLE_W+ENV_W:0] prod;
   stage1_t                        s1_q;

   assign env_s = signed'({1'b0, env_clamp(envelope_i)});
   assign prod  = wave_sample_i * env_s;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q <= '0;
      end else if (active_i && load_i) begin
         s1_q.t1  <= ch_on_i ? T1_W'(prod >>> 8) : '0;
         s1_q.vol <= volume_i;
      end
   end

   assign s1_o = s1_q;

endmodule

// File: rtl/wts_channel_mixer.sv
// Time-multiplexed channel mixer: walks CHANNELS channels per frame, scales each by
// envelope and volume, and emits a saturated signed mix once per frame.
module wts_channel_mixer
   import wts_channel_mixer_pkg::*;
#(
   parameter int unsigned CHANNELS = 5,
   parameter int unsigned OUT_W    = 11
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       active,
   input  logic                       start,
   output logic [CH_W-1:0]            ch_sel,
   input  logic signed [SAMPLE_W-1:0] wave_sample,
   input  logic [ENV_W-1:0]           envelope,
   input  logic [VOL_W-1:0]           volume,
   input  logic [CHANNELS-1:0]        ch_enable,
   output logic signed [OUT_W-1:0]    mix_out,
   output logic                       mix_valid,
   output logic                       busy
);

   // 16 channels of +/-120 need 12 bits; keep one spare and always cover the output range.
   localparam int unsigned ACC_W = (OUT_W + 1 > 13) ? OUT_W + 1 : 13;
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (OUT_W - 1)));
   localparam logic [CH_W-1:0]         LAST_CH = CH_W'(CHANNELS - 1);

   state_e                  state_q;
   logic [CH_W-1:0]         ch_sel_q;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [OUT_W-1:0] mix_q;
   logic                    mix_valid_q;
   logic                    busy_q;
   logic                    t1_vld_q;

   logic [15:0]                en_pad;
   stage1_t                    s1;
   logic signed [T1_W-1:0]     t1_s;
   logic signed [VOL_W:0]      vol_s;
   logic signed [T1_W+VOL_W:0] prod2;
   logic signed [ACC_W-1:0]    term_c;
   logic signed [OUT_W-1:0]    sat_c;

   assign en_pad = 16'(ch_enable);

   wts_channel_scaler u_scaler (
      .clk           (clk),
      .reset         (reset),
      .active_i      (active),
      .load_i        (state_q == ST_RUN),
      .ch_on_i       (en_pad[ch_sel_q]),
      .wave_sample_i (wave_sample),
      .envelope_i    (envelope),
      .volume_i      (volume),
      .s1_o          (s1)
   );

   // Stage 2 term: (t1 * volume) >>> 4, sign-extended to the accumulator width.
   assign t1_s   = s1.t1;
   assign vol_s  = signed'({1'b0, s1.vol});
   assign prod2  = t1_s * vol_s;
   assign term_c = ACC_W'(prod2 >>> 4);

   always_comb begin
      sat_c = OUT_W'(acc_q);
      if (acc_q > SAT_MAX) begin
         sat_c = OUT_W'(SAT_MAX);
      end else if (acc_q < SAT_MIN) begin
         sat_c = OUT_W'(SAT_MIN);
      end
   end

   // Frame FSM, accumulator and output registers; only mix_valid ignores active.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         ch_sel_q    <= '0;
         acc_q       <= '0;
         mix_q       <= '0;
         mix_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         t1_vld_q    <= 1'b0;
      end else begin
         mix_valid_q <= 1'b0;
         if (active) begin
            t1_vld_q <= (state_q == ST_RUN);
            if (t1_vld_q) begin
               acc_q <= acc_q + term_c;
            end
            case (state_q)
               ST_IDLE: begin
                  if (start) begin
                     acc_q    <= '0;
                     ch_sel_q <= '0;
                     busy_q   <= 1'b1;
                     state_q  <= ST_RUN;
                  end
               end
               ST_RUN: begin
                  if (ch_sel_q == LAST_CH) begin
                     state_q <= ST_FLUSH;
                  end else begin
                     ch_sel_q <= ch_sel_q + CH_W'(1);
                  end
               end
               ST_FLUSH: begin
                  state_q <= ST_DONE;
               end
               ST_DONE: begin
                  mix_q       <= sat_c;
                  mix_valid_q <= 1'b1;
                  busy_q      <= 1'b0;
                  ch_sel_q    <= '0;
                  state_q     <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign ch_sel    = ch_sel_q;
   assign mix_out   = mix_q;
   assign mix_valid = mix_valid_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_wts_channel_mixer.sv
// Directed bench for wts_channel_mixer: a 5-channel instance for frame behaviour
// and a 16-channel instance for saturation.
module tb_wts_channel_mixer;

   logic clk = 1'b0;
   logic reset, active, start5, start16;
   logic [3:0] ch_sel5, ch_sel16;
   logic signed [7:0] wave5, wave16;
   logic [8:0] env5, env16;
   logic [3:0] vol5, vol16;
   logic [15:0] en16;
   logic [4:0] en5;
   logic signed [10:0] mix5, mix16;
   logic mv5, mv16, busy5, busy16;

   logic signed [7:0] wave_tab [16];
   logic [8:0]        env_tab  [16];
   logic [3:0]        vol_tab  [16];

   int total = 0;
   int bad = 0;
   int act_div = 1;
   int phase = 0;
   logic last_act;

   assign wave5  = wave_tab[ch_sel5];
   assign env5   = env_tab[ch_sel5];
   assign vol5   = vol_tab[ch_sel5];
   assign wave16 = wave_tab[ch_sel16];
   assign env16  = env_tab[ch_sel16];
   assign vol16  = vol_tab[ch_sel16];
   assign en5    = en16[4:0];

   always #5 clk = ~clk;

   wts_channel_mixer #(.CHANNELS(5), .OUT_W(11)) dut5 (
      .clk(clk), .reset(reset), .active(active), .start(start5), .ch_sel(ch_sel5),
      .wave_sample(wave5), .envelope(env5), .volume(vol5), .ch_enable(en5),
      .mix_out(mix5), .mix_valid(mv5), .busy(busy5)
   );

   wts_channel_mixer #(.CHANNELS(16), .OUT_W(11)) dut16 (
      .clk(clk), .reset(reset), .active(active), .start(start16), .ch_sel(ch_sel16),
      .wave_sample(wave16), .envelope(env16), .volume(vol16), .ch_enable(en16),
      .mix_out(mix16), .mix_valid(mv16), .busy(busy16)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock; active is high on every act_div-th clock.
   task automatic step();
      active   = (phase == 0);
      last_act = active;
      @(posedge clk);
      #1;
      phase = (phase + 1) % act_div;
   endtask

   task automatic set_all(input logic signed [7:0] w, input logic [8:0] e, input logic [3:0] v);
      for (int i = 0; i < 16; i++) begin
         wave_tab[i] = w;
         env_tab[i]  = e;
         vol_tab[i]  = v;
      end
   endtask

   task automatic set_mixed();
      set_all(8'sd0, 9'd0, 4'd0);
      wave_tab[0] = 8'sd127;  env_tab[0] = 9'd256; vol_tab[0] = 4'd15;
      wave_tab[1] = -8'sd128; env_tab[1] = 9'd256; vol_tab[1] = 4'd15;
      wave_tab[2] = 8'sd100;  env_tab[2] = 9'd128; vol_tab[2] = 4'd8;
      wave_tab[3] = -8'sd1;   env_tab[3] = 9'd1;   vol_tab[3] = 4'd1;
      wave_tab[4] = 8'sd50;   env_tab[4] = 9'd0;   vol_tab[4] = 4'd15;
   endtask

   // Expected 5-channel ch_sel after n active edges counted from the start edge.
   function automatic int exp_ch(input int n);
      if (n <= 5) return n - 1;
      if (n <= 7) return 4;
      return 0;
   endfunction

   task automatic run_frame(input int which, input bit hold_start,
                            output int mix, output int edges);
      int   steps;
      bit   done;
      logic mv;
      edges = 0;
      steps = 0;
      done  = 1'b0;
      if (which == 5) start5 = 1'b1; else start16 = 1'b1;
      do step(); while (!last_act);
      edges = 1;
      if (!hold_start) begin
         start5  = 1'b0;
         start16 = 1'b0;
      end
      while (!done && steps < 400) begin
         step();
         steps++;
         if (last_act) edges++;
         if (which == 5) begin
            chk("ch_sel_track", int'(ch_sel5), exp_ch(edges));
            chk("busy_track", int'(busy5), int'(edges < 8));
         end
         mv = (which == 5) ? mv5 : mv16;
         if (mv) done = 1'b1;
      end
      start5  = 1'b0;
      start16 = 1'b0;
      chk("frame_done", int'(done), 1);
      mix = (which == 5) ? int'(mix5) : int'(mix16);
      step();
      mv = (which == 5) ? mv5 : mv16;
      chk("mv_width", int'(mv), 0);
   endtask

   initial begin
      int m, e, pulses;
      reset = 1'b1; active = 1'b0; start5 = 1'b0; start16 = 1'b0; en16 = '0;
      set_all(8'sd0, 9'd0, 4'd0);
      repeat (3) step();
      reset = 1'b0;
      chk("rst_mix", int'(mix5), 0);
      chk("rst_mv", int'(mv5), 0);
      chk("rst_busy", int'(busy5), 0);
      chk("rst_ch_sel", int'(ch_sel5), 0);
      chk("rst_mix16", int'(mix16), 0);

      // ch0 only at full positive scale
      wave_tab[0] = 8'sd127; env_tab[0] = 9'd256; vol_tab[0] = 4'd15;
      en16 = 16'h0001;
      run_frame(5, 1'b0, m, e);
      chk("ch0_mix", m, 119);
      chk("ch0_latency", e, 8);

      // all channels full negative
      set_all(-8'sd128, 9'd256, 4'd15);
      en16 = 16'h001F;
      run_frame(5, 1'b0, m, e);
      chk("neg_all_mix", m, -600);
      chk("neg_all_busy", int'(busy5), 0);

      // ch2 only, half envelope, then clamped and full envelope
      set_all(8'sd0, 9'd0, 4'd0);
      wave_tab[2] = 8'sd100; env_tab[2] = 9'd128; vol_tab[2] = 4'd8;
      en16 = 16'h0004;
      run_frame(5, 1'b0, m, e);
      chk("ch2_half_env", m, 25);
      env_tab[2] = 9'd300;
      run_frame(5, 1'b0, m, e);
      chk("ch2_env300", m, 50);
      env_tab[2] = 9'd256;
      run_frame(5, 1'b0, m, e);
      chk("ch2_env256", m, 50);

      // mixed channels incl. floor rounding of a tiny negative term
      set_mixed();
      en16 = 16'h001F;
      run_frame(5, 1'b0, m, e);
      chk("mixed_mix", m, 23);
      en16 = 16'h001D;
      run_frame(5, 1'b0, m, e);
      chk("mixed_ch1_off", m, 143);

      // start held high through RUN and the DONE cycle: one frame only
      en16 = 16'h001F;
      run_frame(5, 1'b1, m, e);
      chk("hold_start_mix", m, 23);
      chk("hold_start_lat", e, 8);
      pulses = 0;
      repeat (12) begin
         step();
         if (mv5) pulses++;
      end
      chk("hold_start_extra", pulses, 0);
      chk("hold_start_idle_busy", int'(busy5), 0);

      // reset mid-frame aborts
      set_all(8'sd10, 9'd256, 4'd15);
      start5 = 1'b1;
      do step(); while (!last_act);
      start5 = 1'b0;
      repeat (3) step();
      chk("pre_reset_busy", int'(busy5), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort_mix", int'(mix5), 0);
      chk("abort_busy", int'(busy5), 0);
      chk("abort_ch_sel", int'(ch_sel5), 0);
      pulses = 0;
      repeat (20) begin
         step();
         if (mv5) pulses++;
      end
      chk("abort_no_valid", pulses, 0);

      // active 1-in-4: same result, state holds on idle clocks
      set_mixed();
      act_div = 4;
      phase = 0;
      run_frame(5, 1'b0, m, e);
      chk("slow_mix", m, 23);
      chk("slow_latency", e, 8);
      act_div = 1;
      phase = 0;

      // 16 channels saturate both ways
      set_all(8'sd127, 9'd256, 4'd15);
      en16 = 16'hFFFF;
      run_frame(16, 1'b0, m, e);
      chk("sat_pos", m, 1023);
      chk("sat_latency", e, 19);
      set_all(-8'sd128, 9'd256, 4'd15);
      run_frame(16, 1'b0, m, e);
      chk("sat_neg", m, -1024);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
